pipelined_barrel_shifter: RTL
=============================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined barrel shifter; successor to the single-mode 32-bit combinational arithmetic right shifter.
- Supports logical left, logical right, arithmetic right and rotate right at configurable width.
- Registers are split across STAGES pipeline stages, with a valid/ready handshake, backpressure, flush and a passthrough tag.
- Sits beside the ALU as the shift unit for multi-cycle and pipelined datapath variants.

Parameters:
- WIDTH, 32: data width; power of two, at least 8.
- STAGES, 1: number of pipeline register stages; range 1..$clog2(WIDTH).
- TAG_W, 5: width of the sideband tag carried alongside each operation (for example, a destination register index).

Ports:
- i_clk, input, 1: clock; all state updates on the rising edge.
- i_rst_n, input, 1: asynchronous, active-low reset.
- i_flush, input, 1: synchronous flush; invalidates every in-flight operation.
- i_valid, input, 1: input operation valid.
- o_ready, output, 1: shifter can accept an input this cycle.
- i_op, input, 2: shift mode; 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- i_data, input, WIDTH: operand.
- i_shamt, input, $clog2(WIDTH): shift amount, unsigned.
- i_tag, input, TAG_W: sideband tag.
- o_valid, output, 1: result valid.
- i_ready, input, 1: downstream accepts the result.
- o_data, output, WIDTH: result.
- o_tag, output, TAG_W: tag of the result.

Behaviour:
- Shift network: $clog2(WIDTH) binary levels; level k shifts by 2^k when i_shamt[k] is set.
  - Levels are grouped into STAGES contiguous groups of ceil(levels/STAGES) levels each; the last group may be smaller.
  - A register sits after each group.
- Fill rules:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the original i_data[WIDTH-1]; the sign is captured at input and carried down the pipe.
  - ROR wraps bits around; shamt 0 returns the operand unchanged for every op.
- Op, sign, remaining shamt bits and tag travel with the data in each stage register.
- Latency: exactly STAGES cycles from input handshake to o_valid when there is no stall.
- Throughput: one operation per cycle.
- Handshake:
  - Input transfer occurs when i_valid && o_ready.
  - Output transfer occurs when o_valid && i_ready.
  - Global advance enable: adv = i_ready || !o_valid.
  - o_ready = adv (combinational path from i_ready is allowed).
  - When adv=0 every stage holds its contents; o_data and o_tag stay stable while o_valid=1 and i_ready=0.
  - Bubbles are not collapsed; an empty stage still waits on adv.
- Stage valid bits: stage 0 loads i_valid && adv; stage n loads stage n-1 valid when adv.
- Flush:
  - On i_flush=1 at a clock edge, all stage valid bits clear, including o_valid.
  - An input presented in the same cycle is dropped; data registers are don't-care.
  - o_ready is unaffected by flush.
- Reset (i_rst_n low, asynchronous):
  - All stage valid bits are 0, so o_valid=0.
  - o_data is 0 and o_tag is 0.
  - o_ready is 1 after reset because o_valid=0.
  - Reset mid-operation discards all in-flight work.
- Data registers: update only when adv=1 and the incoming valid is 1; they hold otherwise, to save power.
- i_op is decoded in stage 0 only; a reserved encoding does not exist (all four codes are defined).
- An i_shamt of WIDTH-1 is the maximum; out-of-range amounts cannot be expressed.

Decomposition:
- Package shift_pkg:
  - enum shift_op_e {SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ROR=2'b11}.
  - Function levels_per_stage(WIDTH, STAGES).
- Sub-module shift_level:
  - Combinational single-level shifter, parametrised by WIDTH and DIST.
  - Takes op, sign and enable; instantiated $clog2(WIDTH) times via generate.
- Top level owns the stage registers, valid chain and handshake.

Test Plan:
- WIDTH=32, STAGES=1, SRA, data 0x8000_00F0, shamt 4 -> o_data 0xF800_000F, o_valid exactly 1 cycle after the input handshake.
- SRL 0x8000_00F0 by 4 -> 0x0800_000F; SLL 0x8000_00F0 by 4 -> 0x0000_0F00; ROR 0x8000_00F0 by 4 -> 0x0800_000F; ROR 0x0000_0001 by 1 -> 0x8000_0000.
- STAGES=3: back-to-back inputs with tags 1..8 and i_ready=1 -> results in order, tags 1..8, first result after 3 cycles, then 1 per cycle.
- STAGES=3 backpressure: hold i_ready=0 for 4 cycles mid-stream -> o_ready=0, o_data and o_tag stable, no loss or duplication after release.
- Flush with 3 operations in flight, plus an input in the same cycle -> o_valid=0 next cycle; no flushed tag ever appears at the output.
- Assert i_rst_n=0 asynchronously mid-stream -> o_valid, o_data and o_tag are 0 immediately; after release, o_ready=1 and a new op SRA 0xFFFF_FFFF by 31 -> 0xFFFF_FFFF.

Source files
------------

// File: rtl/pipelined_barrel_shifter_pkg.sv
// pipelined_barrel_shifter_pkg: shared shift-op encoding and pipeline partitioning helper.
//   shift_op_e       : SLL/SRL/SRA/ROR encoding of the 2-bit op field
//   levels_per_stage : number of binary shift levels grouped into each pipeline stage
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_e;

    function automatic int levels_per_stage(int width, int stages);
        return ($clog2(width) + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: request/response bundle of the shift unit.
//   request : i_valid/o_ready handshake, i_op, i_data, i_shamt, i_tag, plus i_flush
//   response: o_valid/i_ready handshake, o_data, o_tag
//   slave modport is the shifter, master modport is the requester/consumer.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int SW = $clog2(WIDTH);

    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_data;
    logic [SW-1:0]    i_shamt;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic [TAG_W-1:0] o_tag;

    modport slave (
        input  i_flush, i_valid, i_op, i_data, i_shamt, i_tag, i_ready,
        output o_ready, o_valid, o_data, o_tag
    );

    modport master (
        output i_flush, i_valid, i_op, i_data, i_shamt, i_tag, i_ready,
        input  o_ready, o_valid, o_data, o_tag
    );
endinterface

// File: rtl/pipelined_barrel_shifter_level.sv
// shift_level: one combinational level of the barrel shifter, shifting by DIST when en is set.
//   op   : shift mode
//   sign : operand sign captured at pipeline entry, used as SRA fill
//   en   : shift-amount bit for this level
//   d/q  : data in / data out
module shift_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  shift_op_e        op,
    input  logic             sign,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [DIST-1:0]  fill;
    logic [WIDTH-1:0] r;

    always_comb begin
        fill = {DIST{op == SHIFT_SRA && sign}};
        r    = op == SHIFT_SLL ? d << DIST :
               op == SHIFT_ROR ? {d[DIST-1:0], d[WIDTH-1:DIST]} :
                                 {fill, d[WIDTH-1:DIST]};
        q    = en ? r : d;
    end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: SLL/SRL/SRA/ROR barrel shifter split over STAGES register stages.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : slave side of pipelined_barrel_shifter_if (request, response, flush)
module pipelined_barrel_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input logic                       i_clk,
    input logic                       i_rst_n,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int L   = $clog2(WIDTH);
    localparam int LPS = levels_per_stage(WIDTH, STAGES);

    logic adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_st
        localparam int LO = s * LPS < L ? s * LPS : L;
        localparam int HI = (s + 1) * LPS < L ? (s + 1) * LPS : L;
        localparam int N  = HI - LO;

        logic             v_in, v_q;
        logic [WIDTH-1:0] d_in, d_q;
        logic [TAG_W-1:0] t_in, t_q;
        logic [WIDTH-1:0] ch [N+1];

        if (s == 0) begin : g_in
            assign v_in = bus.i_valid;
            assign d_in = bus.i_data;
            assign t_in = bus.i_tag;
        end else begin : g_in
            assign v_in = g_st[s-1].v_q;
            assign d_in = g_st[s-1].d_q;
            assign t_in = g_st[s-1].t_q;
        end

        assign ch[0] = d_in;

        // Trailing stages can end up with no levels; they only retime data and tag.
        if (N > 0) begin : g_sh
            shift_op_e       op;
            logic            sign;
            logic [L-LO-1:0] rem;

            // Only the not-yet-consumed shamt bits travel on, renumbered from bit 0.
            if (s == 0) begin : g_c
                assign op   = shift_op_e'(bus.i_op);
                assign sign = bus.i_data[WIDTH-1];
                assign rem  = bus.i_shamt;
            end else begin : g_c
                assign op   = g_st[s-1].g_sh.g_nx.op_q;
                assign sign = g_st[s-1].g_sh.g_nx.sign_q;
                assign rem  = g_st[s-1].g_sh.g_nx.rem_q;
            end

            for (genvar j = 0; j < N; j++) begin : g_lvl
                shift_level #(.WIDTH(WIDTH), .DIST(1 << (LO + j))) u_lvl (
                    .op  (op),
                    .sign(sign),
                    .en  (rem[j]),
                    .d   (ch[j]),
                    .q   (ch[j+1])
                );
            end

            if (HI < L) begin : g_nx
                shift_op_e       op_q;
                logic            sign_q;
                logic [L-HI-1:0] rem_q;

                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        op_q   <= SHIFT_SLL;
                        sign_q <= 1'b0;
                        rem_q  <= '0;
                    end else if (adv && v_in) begin
                        op_q   <= op;
                        sign_q <= sign;
                        rem_q  <= rem[L-LO-1:N];
                    end
                end
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                v_q <= 1'b0;
                d_q <= '0;
                t_q <= '0;
            end else begin
                v_q <= bus.i_flush ? 1'b0 : adv ? v_in : v_q;
                if (adv && v_in) begin
                    d_q <= ch[N];
                    t_q <= t_in;
                end
            end
        end
    end

    // Whole pipe advances together; bubbles are deliberately not collapsed.
    assign adv         = bus.i_ready || !g_st[STAGES-1].v_q;
    assign bus.o_ready = adv;
    assign bus.o_valid = g_st[STAGES-1].v_q;
    assign bus.o_data  = g_st[STAGES-1].d_q;
    assign bus.o_tag   = g_st[STAGES-1].t_q;
endmodule
